// File: rtl/oam_dma.sv
// Sprite-DMA sequencer: on a CPU write to DMA_REG, halts the CPU and copies one
// 256-byte PRG page into OAM, one access per CPU cycle strobe.
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_w,
    input  logic [7:0]  oam_start,
    output logic        halt,
    output logic        prg_req,
    output logic [15:0] prga,
    input  logic [7:0]  prgi,
    output logic [7:0]  oama,
    output logic [7:0]  oamd,
    output logic        oamw,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StDummy, StAlign, StRead, StWrite} state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] base_q, base_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] buf_q, buf_d;
    logic       par_q, par_d;

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            base_q  <= 8'h00;
            idx_q   <= 8'h00;
            buf_q   <= 8'h00;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        base_d  = base_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        par_d   = par_q ^ ce_cpu;
        halt    = 1'b0;
        prg_req = 1'b0;
        prga    = 16'h0000;
        oama    = 8'h00;
        oamd    = 8'h00;
        oamw    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ce_cpu && cpu_w && (cpu_a == DMA_REG)) begin
                    page_d  = cpu_o;
                    base_d  = oam_start;
                    idx_d   = 8'h00;
                    state_d = StDummy;
                end
            end
            StDummy: begin
                halt = 1'b1;
                // An odd CPU cycle at this point costs one extra alignment cycle.
                if (ce_cpu) state_d = par_q ? StAlign : StRead;
            end
            StAlign: begin
                halt = 1'b1;
                if (ce_cpu) state_d = StRead;
            end
            StRead: begin
                halt    = 1'b1;
                prg_req = 1'b1;
                prga    = {page_q, idx_q};
                if (ce_cpu) begin
                    buf_d   = prgi;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                halt = 1'b1;
                oama = base_q + idx_q;
                oamd = buf_q;
                if (ce_cpu) begin
                    oamw = 1'b1;
                    if (idx_q == 8'hFF) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy = halt;
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a strobe-counting reference model checked every clock.
module tb_oam_dma;

    logic        clock25;
    logic        reset_n;
    logic        ce_cpu;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_o;
    logic        cpu_w;
    logic [7:0]  oam_start;
    logic        halt;
    logic        prg_req;
    logic [15:0] prga;
    logic [7:0]  prgi;
    logic [7:0]  oama;
    logic [7:0]  oamd;
    logic        oamw;
    logic        busy;

    oam_dma #(.DMA_REG(16'h4014)) dut (
        .clock25   (clock25),
        .reset_n   (reset_n),
        .ce_cpu    (ce_cpu),
        .cpu_a     (cpu_a),
        .cpu_o     (cpu_o),
        .cpu_w     (cpu_w),
        .oam_start (oam_start),
        .halt      (halt),
        .prg_req   (prg_req),
        .prga      (prga),
        .prgi      (prgi),
        .oama      (oama),
        .oamd      (oamd),
        .oamw      (oamw),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] prg [65536];
    logic [7:0] oam [256];

    int halt_strobes = 0;
    int oamw_cnt     = 0;
    int seen_prg     = 0;

    // Reference model: a transfer is m_len halted strobes; the last 512 alternate read/write.
    logic       m_active = 1'b0;
    logic       m_par    = 1'b0;
    int         m_done   = 0;
    int         m_len    = 0;
    logic [7:0] m_page   = 8'h00;
    logic [7:0] m_base   = 8'h00;
    int         k, lead, j, byt;
    logic [35:0] exp_v, act_v, mask_v;

    initial clock25 = 1'b0;
    always #5 clock25 = ~clock25;

    always @(posedge clock25) prgi <= prg[prga];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always begin
        @(negedge clock25);
        #4;
        act_v = {halt, busy, prg_req, oamw, prga, oama, oamd};
        if (!reset_n) begin
            m_active = 1'b0;
            m_par    = 1'b0;
            chk("reset_outputs", 64'(act_v), 64'd0);
        end else begin
            exp_v  = '0;
            mask_v = '1;
            if (m_active) begin
                exp_v[35] = 1'b1;
                exp_v[34] = 1'b1;
                k    = m_done + 1;
                lead = m_len - 512;
                if (k > lead) begin
                    j   = k - lead;
                    byt = (j - 1) / 2;
                    if (j % 2 == 1) begin
                        exp_v[33]    = 1'b1;
                        exp_v[31:16] = {m_page, byt[7:0]};
                        mask_v[15:0] = '0;
                    end else begin
                        exp_v[32]     = ce_cpu;
                        exp_v[15:8]   = 8'(m_base + byt[7:0]);
                        exp_v[7:0]    = prg[{m_page, byt[7:0]}];
                        mask_v[31:16] = '0;
                    end
                end else begin
                    mask_v[31:0] = '0;
                end
            end
            chk("cycle", 64'(act_v & mask_v), 64'(exp_v & mask_v));

            if (oamw) begin
                oam[oama] = oamd;
                oamw_cnt++;
            end
            if (ce_cpu && halt) halt_strobes++;
            if (prg_req) seen_prg++;
            if (ce_cpu) begin
                if (m_active) begin
                    m_done++;
                    if (m_done == m_len) m_active = 1'b0;
                end else if (cpu_w && cpu_a == 16'h4014) begin
                    m_active = 1'b1;
                    m_done   = 0;
                    // Parity seen at the dummy cycle is the inverse of parity now.
                    m_len    = m_par ? 513 : 514;
                    m_page   = cpu_o;
                    m_base   = oam_start;
                end
                m_par = ~m_par;
            end
        end
    end

    task automatic cyc(input logic w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clock25);
        ce_cpu = 1'b1;
        cpu_w  = w;
        cpu_a  = a;
        cpu_o  = d;
        @(negedge clock25);
        ce_cpu = 1'b0;
        cpu_w  = 1'b0;
        cpu_a  = 16'h0000;
        cpu_o  = 8'h00;
        @(negedge clock25);
    endtask

    task automatic trigger(input logic [7:0] pg, input logic dummy_par);
        int guard = 0;
        while (((m_par ^ 1'b1) != dummy_par) && guard < 4) begin
            cyc(1'b0, 16'h0000, 8'h00);
            guard++;
        end
        cyc(1'b1, 16'h4014, pg);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (halt && n < 700) begin
            cyc(1'b0, 16'h0000, 8'h00);
            n++;
        end
        if (halt) chk({name, "_timeout"}, 64'(halt), 64'd0);
    endtask

    task automatic clear_counts();
        halt_strobes = 0;
        oamw_cnt     = 0;
        seen_prg     = 0;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    endtask

    function automatic int oam_errs_xor(input logic [7:0] base, input logic [7:0] key);
        int e = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(base + 8'(i));
            if (oam[a] !== (8'(i) ^ key)) e++;
        end
        return e;
    endfunction

    initial begin
        reset_n   = 1'b0;
        ce_cpu    = 1'b0;
        cpu_a     = 16'h0000;
        cpu_o     = 8'h00;
        cpu_w     = 1'b0;
        oam_start = 8'h00;
        for (int i = 0; i < 65536; i++) prg[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            prg[16'h0200 + i] = 8'(i) ^ 8'h5A;
            prg[16'h0300 + i] = 8'(i);
        end
        repeat (4) @(negedge clock25);
        chk("reset_halt", 64'(halt), 64'd0);
        chk("reset_prga", 64'(prga), 64'd0);
        reset_n = 1'b1;
        repeat (2) cyc(1'b0, 16'h0000, 8'h00);

        // 1: even parity copy
        clear_counts();
        oam_start = 8'h00;
        trigger(8'h02, 1'b0);
        wait_done("t1");
        chk("t1_halt_strobes", 64'(halt_strobes), 64'd513);
        chk("t1_oamw_count", 64'(oamw_cnt), 64'd256);
        chk("t1_oam_errs", 64'(oam_errs_xor(8'h00, 8'h5A)), 64'd0);
        chk("t1_oam00", 64'(oam[8'h00]), 64'h5A);
        chk("t1_oamFF", 64'(oam[8'hFF]), 64'hA5);

        // 2: odd parity copy
        clear_counts();
        trigger(8'h02, 1'b1);
        wait_done("t2");
        chk("t2_halt_strobes", 64'(halt_strobes), 64'd514);
        chk("t2_oamw_count", 64'(oamw_cnt), 64'd256);
        chk("t2_oam_errs", 64'(oam_errs_xor(8'h00, 8'h5A)), 64'd0);

        // 3: OAM address wrap
        clear_counts();
        oam_start = 8'hF0;
        trigger(8'h03, 1'b0);
        oam_start = 8'h00;
        wait_done("t3");
        chk("t3_oamF0", 64'(oam[8'hF0]), 64'h00);
        chk("t3_oamFF", 64'(oam[8'hFF]), 64'h0F);
        chk("t3_oam00", 64'(oam[8'h00]), 64'h10);
        chk("t3_oamEF", 64'(oam[8'hEF]), 64'hFF);

        // 4: non-trigger accesses
        clear_counts();
        cyc(1'b1, 16'h4015, 8'h02);
        cyc(1'b0, 16'h4014, 8'h02);
        repeat (3) cyc(1'b0, 16'h0000, 8'h00);
        chk("t4_halt", 64'(halt), 64'd0);
        chk("t4_halt_strobes", 64'(halt_strobes), 64'd0);
        chk("t4_oamw_count", 64'(oamw_cnt), 64'd0);
        chk("t4_prg_req_seen", 64'(seen_prg), 64'd0);

        // 5: reset mid-transfer
        clear_counts();
        trigger(8'h02, 1'b0);
        for (int n = 0; n < 400 && oamw_cnt < 100; n++) cyc(1'b0, 16'h0000, 8'h00);
        chk("t5_reached_100", 64'(oamw_cnt), 64'd100);
        reset_n = 1'b0;
        #1;
        chk("t5_halt_now", 64'({halt, busy, prg_req, oamw}), 64'd0);
        repeat (3) cyc(1'b0, 16'h0000, 8'h00);
        chk("t5_no_more_oamw", 64'(oamw_cnt), 64'd100);
        reset_n = 1'b1;
        cyc(1'b0, 16'h0000, 8'h00);
        clear_counts();
        trigger(8'h02, 1'b0);
        wait_done("t5");
        chk("t5_oamw_count", 64'(oamw_cnt), 64'd256);
        chk("t5_oam_errs", 64'(oam_errs_xor(8'h00, 8'h5A)), 64'd0);

        // 6: re-trigger while busy
        clear_counts();
        trigger(8'h02, 1'b0);
        for (int n = 0; n < 5 && !prg_req; n++) cyc(1'b0, 16'h0000, 8'h00);
        chk("t6_in_read", 64'(prg_req), 64'd1);
        cyc(1'b1, 16'h4014, 8'h03);
        wait_done("t6");
        chk("t6_oamw_count", 64'(oamw_cnt), 64'd256);
        chk("t6_halt_strobes", 64'(halt_strobes), 64'd513);
        chk("t6_oam_errs", 64'(oam_errs_xor(8'h00, 8'h5A)), 64'd0);
        chk("t6_oam10", 64'(oam[8'h10]), 64'h4A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA sequencer for the Dendy core. Detects a CPU write to the DMA register, stalls the CPU, and copies one 256-byte page from shared PRG memory into sprite OAM. Copying is paced one access per CPU cycle strobe. It sits between the CPU bus, the PRG memory port, and the OAM write port, and owns the PRG port while a transfer runs.

## Interface

**Parameters**
- `DMA_REG`, default 16'h4014: CPU address that triggers a transfer.

**Ports**
- `clock25` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ce_cpu` in 1: one-clock CPU cycle strobe; consecutive strobes are ≥2 clocks apart.
- `cpu_a` in 16: CPU address bus.
- `cpu_o` in 8: CPU write data.
- `cpu_w` in 1: CPU write strobe.
- `oam_start` in 8: current OAMADDR from the PPU, sampled at trigger.
- `halt` out 1: CPU stall; top level gates the CPU clock enable with `ce_cpu & ~halt`.
- `prg_req` out 1: high while DMA owns the PRG port; top muxes `prga` onto memory.
- `prga` out 16: PRG read address.
- `prgi` in 8: PRG read data; registered memory, valid 1 clock after `prga`.
- `oama` out 8: OAM write address.
- `oamd` out 8: OAM write data.
- `oamw` out 1: OAM write strobe, one clock wide.
- `busy` out 1: transfer in progress (equals `halt`).

## Operation

**Registers**
- `page`[8]
- `base`[8]
- `idx`[8]
- `buf`[8]
- `par`[1]: CPU cycle parity. Toggles on every `ce_cpu`, including during DMA. Reset value 0.

**States**

IDLE
- All outputs low.
- Transition: on `ce_cpu & cpu_w & cpu_a==DMA_REG`, latch `page<=cpu_o`, `base<=oam_start`, `idx<=0`, then go to DUMMY.

DUMMY
- `halt=1`.
- On the next `ce_cpu`: go to ALIGN if `par==1` (value before the toggle), else go to READ.

ALIGN
- `halt=1`.
- On the next `ce_cpu`: go to READ.

READ
- `halt=1`, `prg_req=1`, `prga={page,idx}`, held for the whole state.
- On `ce_cpu`: `buf<=prgi`, then go to WRITE.

WRITE
- `halt=1`, `prg_req=0`, `oama=base+idx` (mod 256), `oamd=buf`.
- On `ce_cpu`: pulse `oamw` for that one clock.
- If `idx==8'hFF`, go to IDLE. Otherwise `idx<=idx+1` and go to READ.

**Rules**
- Writes to `DMA_REG` outside IDLE are ignored; the CPU is halted anyway.
- Writes to other addresses are ignored.
- `oama` wraps mod 256. With `base=8'hF0`, byte 0x10 lands at OAM 0x00.
- `prga` low byte never carries into `page`; exactly one page is read.
- Reset mid-transfer: immediate return to IDLE, all outputs low, `par=0`. No further `oamw` is issued. Partially written OAM is left as is.

## Timing

- `halt` rises on the clock edge after the triggering `ce_cpu`. The CPU never sees a ce for the cycle following the write.
- Transfer length in CPU cycles (`ce_cpu` strobes with `halt=1`):
  - 513 when `par==0` at the DUMMY tick.
  - 514 when `par==1`.
- `halt` and `busy` fall on the clock edge after the final WRITE `ce_cpu`. The CPU resumes on the next strobe.
- `prga` is stable for ≥2 clocks before the READ strobe samples `prgi`, which satisfies the 1-clock memory latency.
- `oamw` is asserted exactly 256 times per transfer, each on a `ce_cpu` clock, never on consecutive strobes.
- Reset values: `halt`, `busy`, `prg_req`, `oamw` = 0; `prga`, `oama`, `oamd` = 0.

## Test plan

1. **Basic even-parity copy.** Fill PRG 0x0200–0x02FF with `i^8'h5A`, `oam_start=0`, write 8'h02 to 0x4014 with `par=0` at the DUMMY tick.
   - OAM[i]=`i^8'h5A` for all i.
   - `halt` high for 513 strobes.
   - 256 `oamw` pulses.
2. **Odd parity.** Same setup, triggered one CPU cycle later.
   - `halt` high for 514 strobes.
   - Identical OAM contents.
3. **OAM address wrap.** `oam_start=8'hF0`, page 0x03 holding `i`.
   - OAM[0xF0]=0x00, OAM[0xFF]=0x0F, OAM[0x00]=0x10, OAM[0xEF]=0xFF.
4. **Non-trigger writes.** Write to 0x4015, then a read at 0x4014 (`cpu_w=0`).
   - `halt` stays 0.
   - No `oamw`, `prg_req` stays 0.
5. **Reset mid-transfer.** Deassert `reset_n` after 100 `oamw` pulses.
   - All outputs 0 immediately.
   - No further `oamw`.
   - After release, a new trigger performs a full 256-byte copy.
6. **Re-trigger while busy.** Force a second 0x4014 write during READ.
   - Ignored; the transfer count stays 256 and the page is unchanged.
